fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage sitting directly upstream of the decoder. It owns the program counter, drives the instruction memory address, and buffers fetched instructions with their PCs in a small FIFO. Entries go to the decode stage over a valid/ready handshake. A taken branch resolved downstream arrives as a redirect that flushes the queue and reloads the PC.

## Interface
- `PC_WIDTH`, 5: program counter / instruction memory address width.
- `INST_WIDTH`, 32: instruction width.
- `DEPTH`, 4: queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  PC_WIDTH  instruction memory address; equals current PC.
- `imem_inst`  in  INST_WIDTH  instruction memory data; combinational in `imem_addr`, same cycle.
- `fetch_en`  in  1  when 0, no fetch: PC holds, nothing pushed; queue still drains.
- `redirect`  in  1  flush request from a taken branch.
- `redirect_pc`  in  PC_WIDTH  new fetch PC, valid with `redirect`.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  decode accepts head entry.
- `out_inst`  out  INST_WIDTH  head instruction.
- `out_pc`  out  PC_WIDTH  PC of head instruction.
- `count`  out  $clog2(DEPTH)+1  number of entries currently held.

## Operation
- State: `pc`, circular buffer of `DEPTH` {pc, inst} entries, read pointer, write pointer, occupancy `count`.
- pop = `out_valid & out_ready`.
- fetch = `fetch_en & !redirect & (count < DEPTH | pop)`.
- On fetch: push {`pc`, `imem_inst`} at the write pointer, and `pc <= pc + 1` modulo 2^PC_WIDTH. The PC wraps from 31 to 0 silently.
- On pop: advance the read pointer.
- Simultaneous push and pop at full: `count` is unchanged. This is legal and keeps full throughput.
- Redirect has absolute priority:
  - All entries are discarded and `count <= 0`.
  - `pc <= redirect_pc`.
  - No push that cycle.
  - A pop handshaking in the same cycle is void. Decode must drop that instruction.
- `redirect_pc` is taken as-is. No alignment or range check.
- Pointers wrap modulo `DEPTH`.
- `out_inst`/`out_pc` are don't-care when `out_valid` = 0.
- Without `FETCH_BYPASS_EN`, `out_valid = (count != 0)`, which is purely registered.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `pc` = 0, `imem_addr` = 0.
  - `count` = 0, both pointers = 0.
  - `out_valid` = 0, `out_inst` = 0, `out_pc` = 0.
- Fetch-to-output latency is 1 cycle, without bypass. An instruction fetched in cycle t is visible on `out_*` in t+1.
- First `out_valid` comes in the first cycle after the first edge with `rst_n` high and `fetch_en` = 1.
- Throughput is 1 instruction/cycle, sustained, when `out_ready` is held high.
- Redirect in cycle t:
  - `imem_addr` = `redirect_pc` at t+1.
  - `out_valid` = 0 at t+1 (no bypass).
  - First redirected instruction appears at t+2.
- `out_ready` low: the queue fills to `DEPTH`, then fetch stops. The PC holds at the address of the first unfetched instruction.
- Reset asserted mid-operation: all state clears immediately. In-flight entries are lost.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When `count` = 0 and fetch is active, `out_valid` = 1 combinationally, with `out_inst` = `imem_inst` and `out_pc` = `pc`.
  - If `out_ready` is also high, the entry is consumed directly and not pushed.
  - Fetch-to-output latency becomes 0 cycles, and post-redirect delivery starts at t+1.
  - `out_valid` is never asserted in a redirect cycle.
- Not defined: no combinational path from `imem_inst` or `pc` to `out_*`. Behaviour is as in Timing.

## Test plan
- Reset, `fetch_en` = 1, `out_ready` = 1, imem[i] = 0x100+i -> from the 2nd cycle, one entry per cycle with `out_pc` 0,1,2,… and `out_inst` 0x100, 0x101, …; `count` stays 1.
- `out_ready` = 0 for 8 cycles -> `count` reaches 4 and holds; `imem_addr` holds 4; on releasing `out_ready`, `out_pc` 0..3 drain in order with no gaps, then 4, 5, ….
- Full queue, `out_ready` = 1 for one cycle -> one pop and one push in that same cycle; `count` stays 4.
- `redirect` = 1, `redirect_pc` = 0x12 while 3 entries are held -> next cycle `count` = 0, `out_valid` = 0, `imem_addr` = 0x12; following cycle `out_pc` = 0x12.
- PC wrap: `redirect_pc` = 0x1E -> `out_pc` sequence 0x1E, 0x1F, 0x00, 0x01.
- `rst_n` pulsed low mid-stream with 2 entries held -> `out_valid`, `count` and `imem_addr` go to 0 without waiting for a clock edge.
- With `FETCH_BYPASS_EN` -> after reset release, `out_valid` = 1 in the first fetching cycle with `out_pc` = 0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Decode-side handshake of the fetch queue: head entry offered by the
// fetch stage (master) and accepted by the decoder (slave).
interface fetch_queue_if #(
  parameter int PC_WIDTH   = 5,
  parameter int INST_WIDTH = 32
);
  logic                  out_valid;
  logic                  out_ready;
  logic [INST_WIDTH-1:0] out_inst;
  logic [PC_WIDTH-1:0]   out_pc;

  modport master (output out_valid, out_inst, out_pc, input out_ready);
  modport slave  (input out_valid, out_inst, out_pc, output out_ready);
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, drives imem, buffers {pc, inst} in a FIFO.
// Optional macro FETCH_BYPASS_EN lets a fetch go straight to decode when the queue is empty.
module fetch_queue #(
  parameter int PC_WIDTH   = 5,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic [INST_WIDTH-1:0]   imem_inst,
  input  logic                    fetch_en,
  input  logic                    redirect,
  input  logic [PC_WIDTH-1:0]     redirect_pc,
  output logic [$clog2(DEPTH):0]  count,
  fetch_queue_if.master           dec
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0]   pc;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      occ;
  logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];

  logic q_valid;
  logic q_pop;
  logic fetch;
  logic push;

`ifdef FETCH_BYPASS_EN
  logic bypass;

  // An empty queue hands the fetched word straight to decode; if decode takes
  // it the same cycle it never occupies a slot.
  always_comb begin
    q_valid       = (occ != '0);
    q_pop         = q_valid & ~redirect & dec.out_ready;
    fetch         = fetch_en & ~redirect &
                    ((occ < CNT_W'(DEPTH)) | (q_valid & dec.out_ready));
    bypass        = fetch & ~q_valid;
    push          = fetch & ~(bypass & dec.out_ready);
    dec.out_valid = (q_valid & ~redirect) | bypass;
    dec.out_inst  = bypass ? imem_inst : inst_mem[rd_ptr];
    dec.out_pc    = bypass ? pc : pc_mem[rd_ptr];
  end
`else
  // Full-queue fetch is still allowed when the head leaves the same cycle.
  always_comb begin
    q_valid       = (occ != '0);
    q_pop         = q_valid & dec.out_ready;
    fetch         = fetch_en & ~redirect &
                    ((occ < CNT_W'(DEPTH)) | (q_valid & dec.out_ready));
    push          = fetch;
    dec.out_valid = q_valid;
    dec.out_inst  = inst_mem[rd_ptr];
    dec.out_pc    = pc_mem[rd_ptr];
  end
`endif

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (redirect) begin
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (fetch) begin
        pc <= pc + PC_WIDTH'(1);
      end
      if (push) begin
        pc_mem[wr_ptr]   <= pc;
        inst_mem[wr_ptr] <= imem_inst;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (q_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, q_pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign count     = occ;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: per-cycle stimulus table with hand-derived
// count/address expectations, plus a scoreboard of fetched {pc, inst} entries.
module tb_fetch_queue;
  localparam int PW = 5;
  localparam int IW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_en = 1'b0;
  logic          redirect = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_inst;
  logic [$clog2(D):0] count;

  fetch_queue_if #(.PC_WIDTH(PW), .INST_WIDTH(IW)) dec ();

  fetch_queue #(.PC_WIDTH(PW), .INST_WIDTH(IW), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_inst   (imem_inst),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .count       (count),
    .dec         (dec.master)
  );

  always #5 clk = ~clk;

  // Instruction memory: imem[i] = 0x100 + i
  assign imem_inst = 32'h100 + 32'(imem_addr);

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  typedef struct {
    logic          fe;
    logic          rdy;
    logic          rd;
    logic [PW-1:0] rpc;
    int            exp_count;
    int            exp_addr;
  } vec_t;

  ent_t          sb[$];
  logic [PW-1:0] mpc = '0;
  int            checks = 0;
  int            failures = 0;
  vec_t          vecs[28];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rdy, input logic rd,
                               input logic [PW-1:0] rpc);
    fetch_en      = fe;
    dec.out_ready = rdy;
    redirect      = rd;
    redirect_pc   = rpc;
  endtask

  // Compares the DUT against the reference model for the current cycle, then
  // advances the model across the coming rising edge.
  task automatic checkOutput();
    int   sz;
    bit   mfetch;
    bit   byp;
    bit   mvalid;
    ent_t head;
    sz     = sb.size();
    mfetch = fetch_en && !redirect && (sz < D || (sz != 0 && dec.out_ready));
`ifdef FETCH_BYPASS_EN
    byp    = mfetch && (sz == 0);
    mvalid = (sz != 0 && !redirect) || byp;
`else
    byp    = 1'b0;
    mvalid = (sz != 0);
`endif
    check("out_valid", int'(dec.out_valid), int'(mvalid));
    check("count", int'(count), sz);
    check("imem_addr", int'(imem_addr), int'(mpc));
    if (mvalid && dec.out_valid) begin
      head = byp ? ent_t'({mpc, 32'h100 + 32'(mpc)}) : sb[0];
      check("out_pc", int'(dec.out_pc), int'(head.pc));
      check("out_inst", int'(dec.out_inst), int'(head.inst));
    end
    if (redirect) begin
      sb.delete();
      mpc = redirect_pc;
    end else begin
      if (mvalid && dec.out_ready && !byp) void'(sb.pop_front());
      if (mfetch && !(byp && dec.out_ready)) sb.push_back({mpc, 32'h100 + 32'(mpc)});
      if (mfetch) mpc = mpc + 1'b1;
    end
  endtask

  task automatic run_cycle(input logic fe, input logic rdy, input logic rd,
                           input logic [PW-1:0] rpc);
    applyStimulus(fe, rdy, rd, rpc);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    dec.out_ready = 1'b0;

    // fe, rdy, redirect, redirect_pc, count and imem_addr seen before the edge
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 5'h00, 0, 5'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 5'h00, 1, 5'h01};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 5'h00, 1, 5'h02};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 5'h00, 1, 5'h03};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 5'h00, 1, 5'h04};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'h00, 0, 5'h00};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 5'h00, 1, 5'h01};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 5'h00, 2, 5'h02};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 5'h00, 3, 5'h03};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 5'h00, 4, 5'h04};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 5'h00, 4, 5'h04};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 5'h00, 4, 5'h04};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 5'h00, 4, 5'h04};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 5'h00, 4, 5'h04};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 5'h00, 4, 5'h05};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 5'h00, 4, 5'h06};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 5'h00, 4, 5'h06};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 5'h00, 3, 5'h06};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 5'h12, 3, 5'h06};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 5'h00, 0, 5'h12};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 5'h00, 1, 5'h13};
    vecs[21] = '{1'b1, 1'b1, 1'b1, 5'h1E, 1, 5'h14};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 5'h00, 0, 5'h1E};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 5'h00, 1, 5'h1F};
    vecs[24] = '{1'b1, 1'b1, 1'b0, 5'h00, 1, 5'h00};
    vecs[25] = '{1'b1, 1'b1, 1'b0, 5'h00, 1, 5'h01};
    vecs[26] = '{1'b1, 1'b1, 1'b0, 5'h00, 1, 5'h02};
    vecs[27] = '{1'b1, 1'b0, 1'b0, 5'h00, 1, 5'h03};

    #2;
    check("rst_out_valid", int'(dec.out_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_imem_addr", int'(imem_addr), 0);
    check("rst_out_inst", int'(dec.out_inst), 0);
    check("rst_out_pc", int'(dec.out_pc), 0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].fe, vecs[i].rdy, vecs[i].rd, vecs[i].rpc);
      #1;
`ifndef FETCH_BYPASS_EN
      check($sformatf("tbl_count[%0d]", i), int'(count), vecs[i].exp_count);
      check($sformatf("tbl_addr[%0d]", i), int'(imem_addr), vecs[i].exp_addr);
`endif
      checkOutput();
      @(negedge clk);
    end

    // Asynchronous reset mid-stream, observed before any clock edge
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", int'(dec.out_valid), 0);
    check("async_count", int'(count), 0);
    check("async_imem_addr", int'(imem_addr), 0);
    sb.delete();
    mpc = '0;
    fetch_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
